// File: rtl/nvram_pkg.sv
// Shared definitions for the work-RAM side-port arbiter: FSM state encoding,
// requester indices and the default pause padding.
// No ports; imported by nvram_port_arb and nvram_arb_pick.
package nvram_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_PAUSE = 3'd1,
    PAD_IN     = 3'd2,
    GRANT      = 3'd3,
    PAD_OUT    = 3'd4
  } arb_state_t;

  localparam int REQ_NVRAM        = 0;
  localparam int REQ_HISCORE      = 1;
  localparam int PAUSEPAD_DEFAULT = 4;

endpackage

// File: rtl/nvram_arb_pick.sv
// Two-way winner picker: the requester named by ptr wins if it is asking,
// otherwise the other one. ptr held at 0 gives fixed priority to req[0].
// Ports: req (2 level requests), ptr (favoured index), win (one-hot, 0 if none).
module nvram_arb_pick
  import nvram_pkg::*;
(
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] win
);

  always_comb begin
    win = 2'b00;
    if (req[ptr]) begin
      win[ptr] = 1'b1;
    end else if (req[~ptr]) begin
      win[~ptr] = 1'b1;
    end
  end

endmodule

// File: rtl/nvram_port_arb.sv
// Arbitrates the game work-RAM side port between the nvram dump engine (req 0)
// and the hiscore engine (req 1), owning the CPU pause handshake around each grant.
// Latency: grant appears PAUSEPAD+1 cycles after paused is seen; mux adds none.
// Backpressure: requesters hold req until done; the core is held off via pause_cpu,
// and a core that never confirms aborts the request after TIMEOUT cycles (err).
// Ports: clk/reset (sync, active-high); paused in; req[1:0] in; gnt[1:0] out;
// addr0/1, wdata0/1, we0/1 in; ram_addr/ram_wdata/ram_we out; ram_rdata in;
// rdata, pause_cpu, busy, err out.
// Build option: define NVRAM_ARB_RR_EN for round-robin selection (default: req[0] priority).
module nvram_port_arb
  import nvram_pkg::*;
#(
  parameter int AWIDTH   = 8,
  parameter int PAUSEPAD = PAUSEPAD_DEFAULT,
  parameter int TIMEOUT  = 1023
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              paused,
  input  logic [1:0]        req,
  output logic [1:0]        gnt,
  input  logic [AWIDTH-1:0] addr0,
  input  logic [AWIDTH-1:0] addr1,
  input  logic [7:0]        wdata0,
  input  logic [7:0]        wdata1,
  input  logic              we0,
  input  logic              we1,
  output logic [AWIDTH-1:0] ram_addr,
  output logic [7:0]        ram_wdata,
  output logic              ram_we,
  input  logic [7:0]        ram_rdata,
  output logic [7:0]        rdata,
  output logic              pause_cpu,
  output logic              busy,
  output logic              err
);

  localparam int CW = (PAUSEPAD > 0) ? $clog2(PAUSEPAD + 1) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] PAD_LOAD = CW'(PAUSEPAD);
  localparam logic [TW-1:0] T_LAST   = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] T_SAT    = TW'(TIMEOUT);

  arb_state_t    state, state_nxt;
  logic          sel, sel_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [TW-1:0] tcnt, tcnt_nxt;
  logic [1:0]    gnt_nxt;
  logic          pause_nxt;
  logic          err_nxt;
  logic          rr_ptr;
  logic [1:0]    win;

`ifdef NVRAM_ARB_RR_EN
  logic rr_ptr_nxt;

  always_ff @(posedge clk) begin
    if (reset) rr_ptr <= 1'b0;
    else       rr_ptr <= rr_ptr_nxt;
  end
`else
  assign rr_ptr = 1'b0;
`endif

  nvram_arb_pick u_pick (
    .req (req),
    .ptr (rr_ptr),
    .win (win)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      sel       <= 1'b0;
      cnt       <= '0;
      tcnt      <= '0;
      gnt       <= 2'b00;
      pause_cpu <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_nxt;
      sel       <= sel_nxt;
      cnt       <= cnt_nxt;
      tcnt      <= tcnt_nxt;
      gnt       <= gnt_nxt;
      pause_cpu <= pause_nxt;
      err       <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    sel_nxt   = sel;
    cnt_nxt   = cnt;
    tcnt_nxt  = tcnt;
    gnt_nxt   = gnt;
    pause_nxt = pause_cpu;
    err_nxt   = 1'b0;
`ifdef NVRAM_ARB_RR_EN
    rr_ptr_nxt = rr_ptr;
`endif
    case (state)
      IDLE: begin
        if (|win) begin
          sel_nxt   = win[REQ_HISCORE];
          pause_nxt = 1'b1;
          tcnt_nxt  = '0;
          state_nxt = WAIT_PAUSE;
        end
      end
      WAIT_PAUSE: begin
        // A withdrawn request still goes through PAD_OUT so the core gets its unpause pad.
        if (!req[sel]) begin
          cnt_nxt   = PAD_LOAD;
          state_nxt = PAD_OUT;
        end else if (paused) begin
          cnt_nxt   = PAD_LOAD;
          state_nxt = PAD_IN;
        end else if (tcnt == T_LAST) begin
          tcnt_nxt  = T_SAT;
          err_nxt   = 1'b1;
          pause_nxt = 1'b0;
          state_nxt = IDLE;
        end else begin
          tcnt_nxt = tcnt + 1'b1;
        end
      end
      PAD_IN: begin
        // Count only while the core confirms the pause; a core-side reset can drop it.
        if (!req[sel]) begin
          cnt_nxt   = PAD_LOAD;
          state_nxt = PAD_OUT;
        end else if (paused) begin
          if (cnt == '0) begin
            gnt_nxt      = 2'b00;
            gnt_nxt[sel] = 1'b1;
            state_nxt    = GRANT;
          end else begin
            cnt_nxt = cnt - 1'b1;
          end
        end
      end
      GRANT: begin
        if (!req[sel]) begin
          gnt_nxt   = 2'b00;
          cnt_nxt   = PAD_LOAD;
          state_nxt = PAD_OUT;
`ifdef NVRAM_ARB_RR_EN
          rr_ptr_nxt = ~sel;
`endif
        end
      end
      PAD_OUT: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - 1'b1;
        end else if (req[~sel]) begin
          // Chain straight into the other requester while the CPU is still held.
          sel_nxt   = ~sel;
          cnt_nxt   = PAD_LOAD;
          state_nxt = PAD_IN;
        end else begin
          pause_nxt = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ram_addr  = '0;
    ram_wdata = 8'h00;
    ram_we    = 1'b0;
    if (gnt[REQ_NVRAM]) begin
      ram_addr  = addr0;
      ram_wdata = wdata0;
      ram_we    = we0;
    end else if (gnt[REQ_HISCORE]) begin
      ram_addr  = addr1;
      ram_wdata = wdata1;
      ram_we    = we1;
    end
  end

  assign rdata = ram_rdata;
  assign busy  = (state != IDLE);

endmodule

// File: tb/tb_nvram_port_arb.sv
// Bench for nvram_port_arb: scenario tasks drive requests against a simple core
// model (paused follows pause_cpu after a chosen delay) and expect grant/pause
// edges at cycle numbers worked out from the arbiter's timing rules.
module tb_nvram_port_arb;
  localparam int AW = 8;
  localparam int PP = 4;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          paused = 1'b0;
  logic [1:0]    req = 2'b00;
  logic [1:0]    gnt;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [7:0]    wdata0 = 8'h00, wdata1 = 8'h00;
  logic          we0 = 1'b0, we1 = 1'b0;
  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_wdata;
  logic          ram_we;
  logic [7:0]    ram_rdata = 8'h00;
  logic [7:0]    rdata;
  logic          pause_cpu, busy, err;

  nvram_port_arb #(.AWIDTH(AW), .PAUSEPAD(PP), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .paused(paused), .req(req), .gnt(gnt),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .we0(we0), .we1(we1), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_we(ram_we), .ram_rdata(ram_rdata), .rdata(rdata),
    .pause_cpu(pause_cpu), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         total = 0;
  int         bad = 0;
  logic [1:0] exp_gnt = 2'b00;
  bit         exp_err = 1'b0;
  int         exp_ptr = 0;
  bit         started = 1'b0;
  bit         rand_dat = 1'b0;
  bit         core_en = 1'b1;
  int         core_delay = 0;
  int         core_gap = 0;
  int         pcnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_to(input int t);
    while (cyc < t) tick();
  endtask

  // Core model: confirms the pause core_delay cycles after it sees pause_cpu,
  // optionally blips paused low for core_gap cycles right after confirming.
  always @(posedge clk) begin
    #1;
    if (!core_en || !pause_cpu) begin
      pcnt   = 0;
      paused = 1'b0;
    end else begin
      paused = (pcnt >= core_delay) && !(pcnt > core_delay && pcnt <= core_delay + core_gap);
      pcnt++;
    end
  end

  // Requester data and RAM read data.
  always @(posedge clk) begin
    #2;
    ram_rdata = 8'($urandom);
    if (rand_dat) begin
      addr0 = AW'($urandom); addr1 = AW'($urandom);
      wdata0 = 8'($urandom); wdata1 = 8'($urandom);
      we0 = 1'($urandom);    we1 = 1'($urandom);
    end else begin
      addr0 = 8'h2A; wdata0 = 8'h5C; we0 = 1'b1;
      addr1 = 8'h77; wdata1 = 8'h33; we1 = 1'b1;
    end
  end

  // Every cycle: grant matches expectation and the RAM port follows the granted requester only.
  always @(negedge clk) begin : mon
    logic [AW-1:0] ea;
    logic [7:0]    ed;
    logic          ew;
    if (started) begin
      ea = '0; ed = 8'h00; ew = 1'b0;
      if (exp_gnt == 2'b01) begin
        ea = addr0; ed = wdata0; ew = we0;
      end else if (exp_gnt == 2'b10) begin
        ea = addr1; ed = wdata1; ew = we1;
      end
      chk("gnt", gnt, exp_gnt);
      chk("err", err, exp_err);
      chk("ram_addr", ram_addr, ea);
      chk("ram_wdata", ram_wdata, ed);
      chk("ram_we", ram_we, ew);
      chk("rdata", rdata, ram_rdata);
      chk("gnt_wo_pause", (gnt != 2'b00) && !pause_cpu, 0);
    end
  end

  function automatic int pick(input logic [1:0] rq);
`ifdef NVRAM_ARB_RR_EN
    if (rq[exp_ptr]) return exp_ptr;
    return 1 - exp_ptr;
`else
    return rq[0] ? 0 : 1;
`endif
  endfunction

  task automatic do_single(input int r, input int d, input int gap, input int hold, input bit directed);
    int s, g, dd;
    core_en = 1'b1; core_delay = d; core_gap = gap;
    s = cyc; req[r] = 1'b1;
    tick();
    chk("pause_rise", pause_cpu, 1);
    chk("busy_on", busy, 1);
    g = s + d + PP + 3 + gap;
    tick_to(g - 1);
    chk("gnt_early", gnt, 0);
    tick();
    chk("gnt_rise", gnt, 1 << r);
    exp_gnt = 2'(1 << r);
    if (directed) begin
      chk("dir_addr", ram_addr, 8'h2A);
      chk("dir_wdata", ram_wdata, 8'h5C);
      chk("dir_we", ram_we, 1);
    end
    repeat (hold) tick();
    dd = cyc; req[r] = 1'b0; exp_ptr = 1 - r;
    tick();
    chk("gnt_fall", gnt, 0);
    exp_gnt = 2'b00;
    chk("pause_keep", pause_cpu, 1);
    tick_to(dd + PP + 1);
    chk("pause_pad", pause_cpu, 1);
    tick();
    chk("pause_fall", pause_cpu, 0);
    chk("busy_off", busy, 0);
  endtask

  task automatic do_chain(input int d, input int h1, input int h2);
    int s, g, dd, w, o;
    core_en = 1'b1; core_delay = d; core_gap = 0;
    w = pick(2'b11); o = 1 - w;
    s = cyc; req = 2'b11;
    tick();
    chk("pause_rise", pause_cpu, 1);
    g = s + d + PP + 3;
    tick_to(g - 1);
    chk("gnt_early", gnt, 0);
    tick();
    chk("chain_first", gnt, 1 << w);
    exp_gnt = 2'(1 << w);
    repeat (h1) tick();
    dd = cyc; req[w] = 1'b0; exp_ptr = o;
    tick();
    chk("gnt_fall", gnt, 0);
    exp_gnt = 2'b00;
    tick_to(dd + PP + 2);
    chk("chain_pause", pause_cpu, 1);
    g = dd + 2 * PP + 3;
    tick_to(g - 1);
    chk("chain_early", gnt, 0);
    tick();
    chk("chain_second", gnt, 1 << o);
    exp_gnt = 2'(1 << o);
    repeat (h2) tick();
    dd = cyc; req[o] = 1'b0; exp_ptr = w;
    tick();
    exp_gnt = 2'b00;
    tick_to(dd + PP + 1);
    chk("pause_pad", pause_cpu, 1);
    tick();
    chk("pause_fall", pause_cpu, 0);
    chk("busy_off", busy, 0);
  endtask

  task automatic do_cancel(input int r, input int d);
    int s, k, c;
    core_en = 1'b1; core_delay = d; core_gap = 0;
    s = cyc; req[r] = 1'b1;
    tick();
    chk("pause_rise", pause_cpu, 1);
    k = $urandom_range(0, d + PP);
    tick_to(s + 1 + k);
    c = cyc; req[r] = 1'b0;
    tick_to(c + PP + 1);
    chk("cancel_pause", pause_cpu, 1);
    tick();
    chk("cancel_release", pause_cpu, 0);
    chk("busy_off", busy, 0);
  endtask

  task automatic do_timeout(input int r);
    int s;
    core_en = 1'b0;
    s = cyc; req[r] = 1'b1;
    tick();
    chk("pause_rise", pause_cpu, 1);
    tick_to(s + TO);
    chk("err_early", err, 0);
    chk("wait_pause", pause_cpu, 1);
    tick();
    chk("err_pulse", err, 1);
    chk("to_release", pause_cpu, 0);
    exp_err = 1'b1;
    req[r] = 1'b0;
    tick();
    exp_err = 1'b0;
    chk("err_once", err, 0);
    chk("busy_off", busy, 0);
    core_en = 1'b1;
  endtask

  task automatic do_reset_mid(input int r, input int d);
    int s, g;
    core_en = 1'b1; core_delay = d; core_gap = 0;
    s = cyc; req[r] = 1'b1;
    g = s + d + PP + 3;
    tick_to(g);
    chk("rst_pre_gnt", gnt, 1 << r);
    exp_gnt = 2'(1 << r);
    tick();
    reset = 1'b1; req = 2'b00;
    tick();
    exp_gnt = 2'b00;
    chk("rst_gnt", gnt, 0);
    chk("rst_pause", pause_cpu, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b0; exp_ptr = 0;
    tick();
    tick();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (2) tick();
    chk("init_gnt", gnt, 0);
    chk("init_pause", pause_cpu, 0);
    chk("init_err", err, 0);
    chk("init_busy", busy, 0);
    reset = 1'b0;
    started = 1'b1;
    tick();

    do_single(0, 3, 0, 4, 1'b1);
    rand_dat = 1'b1;
    do_chain(2, 3, 3);
    do_timeout(0);
    do_cancel(0, 2);
    do_single(1, 1, 2, 2, 1'b0);
    do_reset_mid(1, 0);
    do_chain(1, 2, 2);
    do_chain(0, 1, 3);

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 4))
        0: do_single($urandom_range(0, 1), $urandom_range(0, 5), $urandom_range(0, 3), $urandom_range(0, 6), 1'b0);
        1: do_chain($urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 5));
        2: do_cancel($urandom_range(0, 1), $urandom_range(0, 5));
        3: do_timeout($urandom_range(0, 1));
        default: do_reset_mid($urandom_range(0, 1), $urandom_range(0, 4));
      endcase
      repeat ($urandom_range(0, 3)) tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nvram_port_arb.md
Name: nvram_port_arb

Overview:
- Arbitrates the game work-RAM side port between two save engines: requester 0 is the nvram dump engine and requester 1 is the hiscore engine.
- Owns the CPU pause handshake. It requests a pause, waits for the core to confirm, pads, grants, then pads again and releases.
- Sits between the save engines and the core RAM B-port. The engines no longer drive pause_cpu themselves.

Parameters:
- AWIDTH, 8: game RAM port address width.
- PAUSEPAD, 4: idle cycles after pause confirm before grant, and after release before unpause.
- TIMEOUT, 1023: cycles to wait for paused before aborting a request.

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high
- paused  in  1  core confirms CPU halted
- req  in  2  per-requester access request, level, held until done
- gnt  out  2  one-hot grant, registered
- addr0 / addr1  in  AWIDTH  requester addresses
- wdata0 / wdata1  in  8  requester write data
- we0 / we1  in  1  requester write enables
- ram_addr  out  AWIDTH  to game RAM port
- ram_wdata  out  8  to game RAM port
- ram_we  out  1  to game RAM port
- ram_rdata  in  8  game RAM read data
- rdata  out  8  ram_rdata broadcast to both requesters
- pause_cpu  out  1  pause request to core
- busy  out  1  state != IDLE
- err  out  1  one-cycle pulse on pause timeout

Behaviour:
- Reset values: gnt=0, pause_cpu=0, err=0, state=IDLE, sel=0, counters=0, RR pointer=0. Reset asserted mid-grant drops gnt and pause_cpu on the next edge; no padding is applied.
- Datapath mux, combinational from registered gnt:
  - gnt[i] high: ram_addr/ram_wdata = addr_i/wdata_i and ram_we = we_i.
  - No grant: ram_addr=0, ram_wdata=0, ram_we=0.
  - A requester's we is ignored unless it holds grant.
- rdata = ram_rdata at all times. The RAM's own read latency applies and the arbiter adds none.
- States and transitions:
  - IDLE: if any req, latch winner into sel, set pause_cpu=1, go WAIT_PAUSE.
  - WAIT_PAUSE: if paused, load cnt=PAUSEPAD and go PAD_IN. Otherwise increment tcnt; at tcnt==TIMEOUT, pulse err, clear pause_cpu and go IDLE.
  - PAD_IN: decrement cnt; when cnt==0, set gnt[sel]=1 and go GRANT. Grant is therefore first visible PAUSEPAD+1 cycles after paused is seen.
  - GRANT: hold while req[sel]. When req[sel]=0, set gnt=0, load cnt=PAUSEPAD and go PAD_OUT.
  - PAD_OUT: decrement cnt; at 0, branch on the other requester:
    - Other req pending: chain. Keep pause_cpu=1, set sel=other, load cnt=PAUSEPAD, go PAD_IN. WAIT_PAUSE is skipped.
    - Otherwise: clear pause_cpu, go IDLE.
- Cancellation: if req[sel] drops in WAIT_PAUSE or PAD_IN, go PAD_OUT with no grant issued.
- Timer gating: the PAD_IN counter holds while paused==0, since a pause may be lost to a core-side reset. The PAD_OUT counter runs regardless.
- Widths: cnt is clog2(PAUSEPAD+1) bits; tcnt is clog2(TIMEOUT+1) bits and saturates. Both are cleared on entry to their state.
- Simultaneous requests in IDLE: fixed priority, req[0] wins.
- gnt is never two-hot, and a grant is never issued while pause_cpu=0.

Optional Feature:
- NVRAM_ARB_RR_EN defined: round-robin winner selection in IDLE and at PAD_OUT chaining.
  - The pointer flips to the non-winner after each completed grant. Cancels and timeouts do not flip it.
  - After reset the pointer favours req[0].
- Undefined: fixed priority, req[0] always wins. PAD_OUT chaining still serves the other requester when only it is pending.

Decomposition:
- Shared package nvram_pkg holds:
  - the state enum constants (IDLE, WAIT_PAUSE, PAD_IN, GRANT, PAD_OUT) with width 3;
  - requester index constants REQ_NVRAM=0 and REQ_HISCORE=1;
  - the default PAUSEPAD.
- One natural sub-module, nvram_arb_pick: 2-way priority/round-robin picker taking req and pointer, returning the one-hot winner.

Test Plan:
- Single request: req=01, paused rises 3 cycles after pause_cpu, PAUSEPAD=4 -> gnt=01 exactly 5 cycles after paused seen. addr0=0x2A, we0=1, wdata0=0x5C reach the RAM port. Drop req -> gnt=00 next edge, pause_cpu=0 after 5 more cycles.
- Simultaneous: req=11 in IDLE, fixed priority -> gnt=01 first. On release, chain: pause_cpu stays 1, gnt=10 after PAUSEPAD+1 cycles, with no WAIT_PAUSE entry.
- Timeout: TIMEOUT=16, paused held 0 -> err pulses 1 cycle at cycle 16, pause_cpu=0, gnt never asserted.
- Write masking: we1=1 while gnt=01 -> ram_we follows we0 only; with no grant, ram_we=0 and ram_addr=0.
- Reset mid-operation: synchronous reset pulse while gnt=10 -> next edge gnt=00, pause_cpu=0, busy=0.
- NVRAM_ARB_RR_EN: req=11 held across 4 grants -> sequence 01, 10, 01, 10. Req[0] cancelled in PAD_IN -> pointer unchanged.
